// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I field-to-word encoder that tags each word with a byte address.
// Optional build macro IMM_CHECK_EN: also flag immediates that do not fit their format.
module instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } fmt_t;

    localparam logic [6:0]  OP_OP     = 7'b0110011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    // Handshake and stage control
    logic s1_valid;
    logic s2_valid;
    logic s2_ready;
    logic s1_xfer;
    logic in_fire;

    // Stage 1 payload
    fmt_t        in_fmt;
    fmt_t        s1_fmt;
    logic [6:0]  s1_op;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_f3;
    logic [6:0]  s1_f7;
    logic [31:0] s1_imm;

    // Packing results
    logic [31:0] pack_word;
    logic        illegal;
    logic        range_err;
    logic        shift_form;

    // Stage 2 and address counter
    logic [31:0]       s2_instr;
    logic              s2_err;
    logic [ADDR_W-1:0] s2_addr;
    logic [ADDR_W-1:0] addr_cnt;

    assign s2_ready = ~s2_valid | out_ready;
    assign in_ready = ~s1_valid | s2_ready;
    assign s1_xfer  = s1_valid & s2_ready;
    assign in_fire  = in_valid & in_ready;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        in_fmt = FMT_X;
        case (in_opcode)
            OP_OP:                     in_fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  in_fmt = FMT_I;
            OP_STORE:                  in_fmt = FMT_S;
            OP_BRANCH:                 in_fmt = FMT_B;
            OP_LUI, OP_AUIPC:          in_fmt = FMT_U;
            OP_JAL:                    in_fmt = FMT_J;
            default:                   in_fmt = FMT_X;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_fire | (s1_valid & ~s2_ready);
        end
    end

    // NOTE: payload registers carry no reset; the stage valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_fmt <= in_fmt;
            s1_op  <= in_opcode;
            s1_rd  <= in_rd;
            s1_rs1 <= in_rs1;
            s1_rs2 <= in_rs2;
            s1_f3  <= in_funct3;
            s1_f7  <= in_funct7;
            s1_imm <= in_imm;
        end
    end

    // slli/srli/srai carry funct7 in the upper bits and a 5-bit shamt
    assign shift_form = (s1_op == OP_IMM) && (s1_f3[1:0] == 2'b01);

    always_comb begin
        pack_word = NOP_WORD;
        illegal   = 1'b0;
        case (s1_fmt)
            FMT_R: pack_word = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
            FMT_I: begin
                if (shift_form) begin
                    pack_word = {s1_f7, s1_imm[4:0], s1_rs1, s1_f3, s1_rd, s1_op};
                end else begin
                    pack_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
                end
            end
            FMT_S: pack_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
            FMT_B: pack_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                                s1_imm[4:1], s1_imm[11], s1_op};
            FMT_U: pack_word = {s1_imm[31:12], s1_rd, s1_op};
            FMT_J: pack_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                s1_rd, s1_op};
            default: begin
                pack_word = NOP_WORD;
                illegal   = 1'b1;
            end
        endcase
    end

`ifdef IMM_CHECK_EN
    logic sext12;
    logic sext13;
    logic sext21;

    // A value is sign-extended from N bits when bits [31:N-1] are all equal
    assign sext12 = (&s1_imm[31:11]) | ~(|s1_imm[31:11]);
    assign sext13 = (&s1_imm[31:12]) | ~(|s1_imm[31:12]);
    assign sext21 = (&s1_imm[31:20]) | ~(|s1_imm[31:20]);

    always_comb begin
        range_err = 1'b0;
        case (s1_fmt)
            FMT_I:   range_err = shift_form ? (s1_imm[31:5] != '0) : ~sext12;
            FMT_S:   range_err = ~sext12;
            FMT_B:   range_err = ~sext13 | s1_imm[0];
            FMT_J:   range_err = ~sext21 | s1_imm[0];
            FMT_U:   range_err = (s1_imm[11:0] != '0);
            default: range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
            s2_addr  <= BASE_ADDR;
        end else begin
            s2_valid <= s1_xfer | (s2_valid & ~out_ready);
            if (s1_xfer) begin
                s2_instr <= pack_word;
                s2_err   <= illegal | range_err;
                s2_addr  <= addr_cnt;
            end
        end
    end

    // clear wins over increment; a word moving this cycle already took the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= BASE_ADDR;
        end else if (clear) begin
            addr_cnt <= BASE_ADDR;
        end else if (s1_xfer) begin
            addr_cnt <= addr_cnt + ADDR_W'(4);
        end
    end

    assign out_valid = s2_valid;
    assign out_instr = s2_instr;
    assign out_err   = s2_err;
    assign out_addr  = s2_addr;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literal cases plus randomized traffic
// compared every cycle against a two-slot behavioural model of the encoder.
module tb_instr_encoder;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0;
`ifdef IMM_CHECK_EN
    localparam bit IMM_CHECK = 1'b1;
`else
    localparam bit IMM_CHECK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoding built from field positions with shifts and masks
    function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [31:0] imm);
        logic [31:0] w;
        logic [31:0] regs;
        logic [31:0] lo;
        bit          bad;
        bit          illegal;
        int          si;
        si      = imm;
        regs    = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        lo      = (32'(rd) << 7) | 32'(op);
        bad     = 1'b0;
        illegal = 1'b0;
        case (op)
            7'h33: w = (32'(f7) << 25) | regs | lo;
            7'h13, 7'h03, 7'h67: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    w   = (32'(f7) << 25) | ((imm % 32) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | lo;
                    bad = (imm > 31);
                end else begin
                    w   = ((imm & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | lo;
                    bad = (si < -2048) || (si > 2047);
                end
            end
            7'h23: begin
                w   = (((imm >> 5) & 32'h7f) << 25) | regs | ((imm & 32'h1f) << 7) | 32'(op);
                bad = (si < -2048) || (si > 2047);
            end
            7'h63: begin
                w   = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) | regs |
                      (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
                bad = (si < -4096) || (si > 4095) || ((imm % 2) != 0);
            end
            7'h37, 7'h17: begin
                w   = (imm & 32'hffff_f000) | lo;
                bad = (imm & 32'hfff) != 0;
            end
            7'h6f: begin
                w   = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21) |
                      (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hff) << 12) | lo;
                bad = (si < -1048576) || (si > 1048575) || ((imm % 2) != 0);
            end
            default: begin
                w       = 32'h13;
                illegal = 1'b1;
            end
        endcase
        return {illegal | (IMM_CHECK & bad), w};
    endfunction

    // Behavioural model: one held input entry and one held output entry
    bit          m1v, m2v;
    logic [6:0]  m1_op, m1_f7;
    logic [4:0]  m1_rd, m1_rs1, m1_rs2;
    logic [2:0]  m1_f3;
    logic [31:0] m1_imm;
    logic [31:0] m2_instr, m2_addr, mcnt;
    bit          m2_err;
    int          n_acc = 0;

    function automatic bit model_in_ready();
        return !m1v || !m2v || out_ready;
    endfunction

    always @(posedge clk) begin
        bit          s2r, inr;
        logic [32:0] r;
        if (!rst_n) begin
            m1v  = 1'b0;
            m2v  = 1'b0;
            mcnt = BASE;
        end else begin
            s2r = !m2v || out_ready;
            inr = !m1v || s2r;
            if (m1v && s2r) begin
                r        = model_enc(m1_op, m1_rd, m1_rs1, m1_rs2, m1_f3, m1_f7, m1_imm);
                m2_instr = r[31:0];
                m2_err   = r[32];
                m2_addr  = mcnt;
                m2v      = 1'b1;
                m1v      = 1'b0;
                mcnt     = mcnt + 32'd4;
            end else if (m2v && out_ready) begin
                m2v = 1'b0;
            end
            if (clear) mcnt = BASE;
            if (in_valid && inr) begin
                m1_op  = in_opcode;
                m1_rd  = in_rd;
                m1_rs1 = in_rs1;
                m1_rs2 = in_rs2;
                m1_f3  = in_funct3;
                m1_f7  = in_funct7;
                m1_imm = in_imm;
                m1v    = 1'b1;
                n_acc++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_instr", out_instr, 32'd0);
            check("rst_out_err", 32'(out_err), 32'd0);
            check("rst_out_addr", out_addr, BASE);
        end else begin
            check("cyc_in_ready", 32'(in_ready), 32'(model_in_ready()));
            check("cyc_out_valid", 32'(out_valid), 32'(m2v));
            if (m2v) begin
                check("cyc_out_instr", out_instr, m2_instr);
                check("cyc_out_addr", out_addr, m2_addr);
                check("cyc_out_err", 32'(out_err), 32'(m2_err));
            end
        end
    end

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        bit acc;
        acc       = 1'b0;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic expect_out(input string name, input logic [31:0] instr,
                              input logic [31:0] addr, input logic err);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got = 1'b1;
                check({name, "_instr"}, out_instr, instr);
                check({name, "_addr"}, out_addr, addr);
                check({name, "_err"}, 32'(out_err), 32'(err));
            end
            @(posedge clk);
            #1;
        end
        if (!got) check({name, "_timeout"}, 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h7f};

    initial begin
        int acc0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_opcode = 7'h13;
        in_rd     = 5'd1;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_funct3 = 3'd0;
        in_funct7 = 7'd0;
        in_imm    = 32'd5;

        // Reset held with input valid
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_addr", out_addr, 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic encodes
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        expect_out("addi", 32'h0050_0093, 32'd0, 1'b0);
        send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        expect_out("add", 32'h0020_81B3, 32'd4, 1'b0);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        expect_out("beq", 32'h0020_8463, 32'd8, 1'b0);
        send(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        expect_out("jal", 32'h0010_00EF, 32'd12, 1'b0);

        // Illegal opcode, then the next word continues the address sequence
        send(7'h7f, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        expect_out("illegal", 32'h0000_0013, 32'd16, 1'b1);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        expect_out("after_illegal", 32'h0050_0093, 32'd20, 1'b0);

        // Immediate range boundaries
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        expect_out("addi_800", 32'h8000_0093, 32'd24, IMM_CHECK);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd6);
        expect_out("beq_6", 32'h0020_8363, 32'd28, 1'b0);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
        expect_out("beq_7", 32'h0020_8363, 32'd32, IMM_CHECK);

        // Backpressure: only two entries fit while the output is stalled
        do_reset();
        out_ready = 1'b0;
        acc0      = n_acc;
        fork
            begin
                for (int k = 1; k <= 4; k++)
                    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
            end
        join_none
        repeat (5) @(posedge clk);
        #1;
        check("bp_accepted", 32'(n_acc - acc0), 32'd2);
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_out("bp0", 32'h0010_0093, 32'd0, 1'b0);
        expect_out("bp1", 32'h0020_0093, 32'd4, 1'b0);
        expect_out("bp2", 32'h0030_0093, 32'd8, 1'b0);
        expect_out("bp3", 32'h0040_0093, 32'd12, 1'b0);
        wait fork;

        // clear coincident with the third transfer
        do_reset();
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        expect_out("clr0", 32'h0010_0093, 32'd0, 1'b0);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        expect_out("clr1", 32'h0020_0093, 32'd4, 1'b0);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        fork
            begin
                clear = 1'b1;
                @(posedge clk);
                #1;
                clear = 1'b0;
            end
        join_none
        expect_out("clr2", 32'h0030_0093, 32'd8, 1'b0);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        expect_out("clr3", 32'h0040_0093, 32'd0, 1'b0);

        // Reset with words in flight discards them
        out_ready = 1'b0;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        do_reset();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        expect_out("midrst_next", 32'h0090_0093, 32'd0, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int idx;
            @(posedge clk);
            #1;
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            clear     = ($urandom_range(0, 31) == 0);
            idx       = $urandom_range(0, 10);
            in_opcode = (idx == 10) ? 7'($urandom) : ops[idx];
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_funct3 = 3'($urandom);
            in_funct7 = 7'($urandom);
            case ($urandom_range(0, 2))
                0:       in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1:       in_imm = 32'($urandom_range(0, 63));
                default: in_imm = $urandom;
            endcase
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
